// File: rtl/jtframe_sdram_pkg.sv
// Shared definitions for the SDRAM ROM arbiter: requester count, default
// address width, FSM state encoding and a one-hot helper.
package jtframe_sdram_pkg;

  localparam int NREQ   = 4;
  localparam int AW_DEF = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Rotating-priority pick: first requester set scanning ptr+1 .. ptr (mod 4).
// Purely combinational, zero latency; no flow control of its own.
module jtframe_rr_pick
  import jtframe_sdram_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      idx,
  output logic            any
);

  always_comb begin
    idx = ptr;
    any = 1'b0;
    // k = NREQ wraps to ptr itself, so the last owner is considered last
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && req[ptr + 2'(k)]) begin
        any = 1'b1;
        idx = ptr + 2'(k);
      end
    end
    grant = any ? onehot(idx) : '0;
  end

endmodule

// File: rtl/jtframe_rom_rrarb.sv
// Round-robin arbiter sharing one SDRAM read port among four ROM requesters.
// Grant one cycle after req is sampled; a new grant waits for the previous access to finish and hold to drop.
module jtframe_rom_rrarb
  import jtframe_sdram_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int TOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    sel,
  output logic [NREQ-1:0]    dok,
  output logic [31:0]        dout,
  output logic               sdram_req,
  input  logic               sdram_ack,
  output logic [AW-1:0]      sdram_addr,
  input  logic               data_rdy,
  input  logic [31:0]        data_read,
  output logic               timeout_err
);

  localparam logic [7:0] TOUT_C = 8'(TOUT);

  state_t          state, state_nxt;
  logic [NREQ-1:0] sel_nxt, dok_nxt;
  logic [31:0]     dout_nxt;
  logic            sdram_req_nxt, terr_nxt;
  logic [AW-1:0]   sdram_addr_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [1:0]      ptr, ptr_nxt, own, own_nxt;
  logic            deliver, tmo;

  logic [NREQ-1:0] pick_grant;
  logic [1:0]      pick_idx;
  logic            pick_any;

  jtframe_rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    dok_nxt        = '0;
    dout_nxt       = dout;
    sdram_req_nxt  = sdram_req;
    sdram_addr_nxt = sdram_addr;
    terr_nxt       = timeout_err;
    cnt_nxt        = cnt;
    ptr_nxt        = ptr;
    own_nxt        = own;
    deliver        = 1'b0;
    tmo            = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!hold && pick_any) begin
          sel_nxt        = pick_grant;
          own_nxt        = pick_idx;
          sdram_addr_nxt = addr[int'(pick_idx)*AW +: AW];
          sdram_req_nxt  = 1'b1;
          state_nxt      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          sdram_req_nxt = 1'b0;
          cnt_nxt       = '0;
          // a controller may return data in the same cycle it accepts
          if (data_rdy) deliver = 1'b1;
          else          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (data_rdy) begin
          deliver = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
          if (cnt_nxt == TOUT_C) tmo = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (deliver) begin
      dout_nxt = data_read;
      dok_nxt  = onehot(own);
    end
    if (tmo) terr_nxt = 1'b1;
    if (deliver || tmo) begin
      ptr_nxt   = own;
      sel_nxt   = '0;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sel         <= '0;
      dok         <= '0;
      dout        <= '0;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      ptr         <= 2'd3;
      own         <= 2'd0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      dok         <= dok_nxt;
      dout        <= dout_nxt;
      sdram_req   <= sdram_req_nxt;
      sdram_addr  <= sdram_addr_nxt;
      timeout_err <= terr_nxt;
      cnt         <= cnt_nxt;
      ptr         <= ptr_nxt;
      own         <= own_nxt;
    end
  end

endmodule
